tl_imem_responder: RTL and testbench
====================================

# tl_imem_responder

TileLink-UH responder that terminates the instruction-fetch master port of the frontend and serves it from an on-chip single-port SRAM. It accepts Get (multi-beat bursts up to MAX_SIZE) for cache-line refills, and PutFullData/PutPartialData so that a loader can preload code. It returns AccessAckData/AccessAck on channel D, with denial for out-of-range or unsupported requests. It sits between the frontend's icache_a_*/icache_d_* port and the instruction memory, and supports one outstanding transaction.

## Interface
- BASE_ADDR, 32'h0, byte base address of the memory window (aligned to 4*DEPTH_WORDS)
- DEPTH_WORDS, 4096, number of 32-bit words; power of two
- MAX_SIZE, 6, largest accepted log2 transfer size (64 B = 16 beats)
- core_clock_i  in  1  sole clock
- core_reset_i  in  1  synchronous, active-high reset
- imem_a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others unsupported
- imem_a_param  in  3  ignored
- imem_a_size  in  4  log2 bytes
- imem_a_address  in  32  byte address
- imem_a_mask  in  4  byte lanes for Put beats
- imem_a_data  in  32  write data
- imem_a_corrupt  in  1  Put beat with corrupt=1 is not written
- imem_a_valid  in  1  A beat valid
- imem_a_ready  out  1  A beat accepted when valid&ready
- imem_d_opcode  out  3  0 AccessAck, 1 AccessAckData
- imem_d_param  out  2  always 0
- imem_d_size  out  4  echo of a_size
- imem_d_denied  out  1  request refused
- imem_d_data  out  32  read data (0 when denied)
- imem_d_corrupt  out  1  set together with denied on AccessAckData
- imem_d_valid  out  1  D beat valid
- imem_d_ready  in  1  D beat consumed when valid&ready

## Operation
- States: IDLE, READ, WRITE, ACK. imem_a_ready = 1 only in IDLE and WRITE (and never while core_reset_i is high).
- beats B = max(1, 2^size/4). Request legal iff opcode in {0,1,4}, size <= MAX_SIZE, address aligned to min(2^size,4)... aligned to 2^size, and [address, address+2^size-1] lies inside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). Word index = (address-BASE_ADDR)>>2, incremented once per beat; a legal burst never wraps.
- IDLE, Get accepted: latch size/denied, load beat counter with B-1, issue SRAM read of the first word in the same cycle, go to READ.
- READ: SRAM read enable = !d_valid | d_ready, so the registered SRAM output is imem_d_data and it holds while stalled. The last beat fires -> IDLE. Sub-word Get returns the whole containing word, with d_size echoed.
- IDLE, Put accepted: the first beat is already written if legal. If B>1 go to WRITE, else ACK. WRITE accepts the remaining B-1 beats, one write per accepted beat, with byte enables = mask (PutFull treats all bits of mask as given). After the final beat -> ACK.
- ACK: d_valid=1, opcode 0, denied latched; on d fire -> IDLE.
- Denied Get: B beats of AccessAckData with data 0, denied=1, corrupt=1; SRAM is not read.
- Denied Put (including unsupported opcode): consume B beats, no SRAM writes, one AccessAck with denied=1. Unsupported opcode uses size-derived B.
- Reset (any state, including mid-burst): state -> IDLE, counter cleared, no further SRAM writes. Reset values: d_valid 0, d_opcode 0, d_param 0, d_size 0, d_denied 0, d_corrupt 0, d_data 0. imem_a_ready is 0 during reset and 1 in the first cycle after reset deasserts.

## Timing
- Get accepted in cycle N: the first D beat is valid at N+1. With d_ready held high, beat k is at N+1+k, so throughput is 1 beat/cycle. a_ready is re-asserted in the cycle after the last beat fires.
- d_ready low: d_valid and all d_* are held stable and the beat counter is frozen. There is no bubble after d_ready returns.
- Put: beats are accepted one per cycle while a_valid=1. The AccessAck is valid in the cycle after the final beat. a_ready=0 while in ACK.
- SRAM write-then-read to the same word in back-to-back transactions returns the new data (the write completes before the read issue cycle).
- The A channel is never accepted while a D response is pending (single outstanding).

## Test plan
- Get size 6 @BASE_ADDR+0x40 after preload 0x1000_0000+i, d_ready=1 -> 16 AccessAckData beats at N+1..N+16, data 0x1000_0010..0x1000_001F, d_size 6, denied 0.
- Same Get with d_ready toggled 1/0 each cycle -> the same 16 values in order, each held stable while stalled, and no beat dropped or duplicated.
- PutPartial size 2, mask 4'b0101, data 0xAABBCCDD to a word holding 0x11223344, then Get size 2 -> AccessAck denied 0; read returns 0x11BB33DD.
- Get size 6 @BASE_ADDR+4*DEPTH_WORDS-0x20 (crosses the end), and opcode 3 size 2 -> 16 beats denied=1, corrupt=1, data 0; single AccessAck denied=1; memory unchanged.
- Put size 4 (4 beats), core_reset_i asserted after beat 2 -> only words 0-1 written, d_valid 0 in the cycle after reset, a_ready 1 in the first cycle after release.
- Get size 0 @BASE_ADDR+3 -> one beat holding the full word at BASE_ADDR, d_size 0.

Source files
------------

// File: rtl/tl_imem_responder.sv
// tl_imem_responder: TileLink-UH responder serving instruction fetch and code preload from a single-port SRAM
// Ports:
//   core_clock_i, core_reset_i                  clock, synchronous active-high reset
//   imem_a_{opcode,param,size,address,mask,data,corrupt,valid}, imem_a_ready   channel A (requests)
//   imem_d_{opcode,param,size,denied,data,corrupt,valid}, imem_d_ready         channel D (responses)
module tl_imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          MAX_SIZE    = 6
) (
    input  logic        core_clock_i,
    input  logic        core_reset_i,
    input  logic [2:0]  imem_a_opcode,
    input  logic [2:0]  imem_a_param,
    input  logic [3:0]  imem_a_size,
    input  logic [31:0] imem_a_address,
    input  logic [3:0]  imem_a_mask,
    input  logic [31:0] imem_a_data,
    input  logic        imem_a_corrupt,
    input  logic        imem_a_valid,
    output logic        imem_a_ready,
    output logic [2:0]  imem_d_opcode,
    output logic [1:0]  imem_d_param,
    output logic [3:0]  imem_d_size,
    output logic        imem_d_denied,
    output logic [31:0] imem_d_data,
    output logic        imem_d_corrupt,
    output logic        imem_d_valid,
    input  logic        imem_d_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT = {2'b0, BASE_ADDR} + 34'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic [13:0]   r_cnt;
    logic [3:0]    r_size;
    logic          r_denied, r_dv;
    logic [AW-1:0] r_idx;

    logic          w_a_fire, w_d_fire, w_is_get, w_legal, w_we, w_re, w_unused;
    logic [33:0]   w_bytes;
    logic [13:0]   w_beats_m1;
    logic [AW-1:0] w_idx0, w_idx;

    assign w_unused   = ^imem_a_param;
    assign w_is_get   = imem_a_opcode == 3'd4;
    assign w_bytes    = 34'd1 << imem_a_size;
    assign w_beats_m1 = (imem_a_size <= 4'd2) ? 14'd0 : (14'd1 << (imem_a_size - 4'd2)) - 14'd1;
    assign w_idx0     = AW'((imem_a_address - BASE_ADDR) >> 2);
    // 34-bit end address so a window ending at 2^32 cannot overflow the range check
    assign w_legal    = (imem_a_opcode == 3'd0 || imem_a_opcode == 3'd1 || w_is_get)
                        && imem_a_size <= 4'(MAX_SIZE)
                        && (({2'b0, imem_a_address} & (w_bytes - 34'd1)) == 34'd0)
                        && imem_a_address >= BASE_ADDR
                        && ({2'b0, imem_a_address} + w_bytes) <= LIMIT;

    assign imem_a_ready = !core_reset_i && (r_state == IDLE || r_state == WRITE);
    assign w_a_fire     = imem_a_valid && imem_a_ready;
    assign w_d_fire     = r_dv && imem_d_ready;
    assign w_idx        = (r_state == IDLE) ? w_idx0 : r_idx;
    // First Put beat is written straight from channel A; later beats use the latched verdict
    assign w_we = w_a_fire && !imem_a_corrupt && ((r_state == IDLE) ? (w_legal && !w_is_get) : !r_denied);
    // Read advances only when the held beat is consumed, so r_rdata doubles as the D data register
    assign w_re = (r_state == IDLE) ? (w_a_fire && w_is_get && w_legal)
                                    : (r_state == READ && w_d_fire && r_cnt != 14'd0 && !r_denied);

    assign imem_d_valid   = r_dv;
    assign imem_d_opcode  = (r_state == READ) ? 3'd1 : 3'd0;
    assign imem_d_param   = 2'd0;
    assign imem_d_size    = r_size;
    assign imem_d_denied  = r_denied;
    assign imem_d_corrupt = (r_state == READ) && r_denied;
    assign imem_d_data    = r_denied ? 32'd0 : r_rdata;

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_a_fire) w_next = w_is_get ? READ : ((w_beats_m1 == 14'd0) ? ACK : WRITE);
            READ:  if (w_d_fire && r_cnt == 14'd0) w_next = IDLE;
            WRITE: if (w_a_fire && r_cnt == 14'd1) w_next = ACK;
            ACK:   if (w_d_fire) w_next = IDLE;
        endcase
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            r_cnt    <= 14'd0;
            r_size   <= 4'd0;
            r_denied <= 1'b0;
            r_dv     <= 1'b0;
            r_idx    <= '0;
            r_rdata  <= 32'd0;
        end else begin
            if (r_state == IDLE && w_a_fire) begin
                r_size   <= imem_a_size;
                r_denied <= !w_legal;
                r_cnt    <= w_beats_m1;
                r_idx    <= w_idx0 + 1'b1;
                r_dv     <= w_is_get || w_beats_m1 == 14'd0;
            end else if (r_state == READ && w_d_fire) begin
                if (r_cnt == 14'd0) r_dv <= 1'b0;
                else begin
                    r_cnt <= r_cnt - 14'd1;
                    r_idx <= r_idx + 1'b1;
                end
            end else if (r_state == WRITE && w_a_fire) begin
                r_cnt <= r_cnt - 14'd1;
                r_idx <= r_idx + 1'b1;
                r_dv  <= r_cnt == 14'd1;
            end else if (r_state == ACK && w_d_fire) r_dv <= 1'b0;
            if (w_re) r_rdata <= r_mem[w_idx];
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (w_we)
            for (int b = 0; b < 4; b++)
                if (imem_a_mask[b]) r_mem[w_idx][8*b +: 8] <= imem_a_data[8*b +: 8];
    end
endmodule

// File: tb/tb_tl_imem_responder.sv
// tb_tl_imem_responder: directed vector table plus burst, stall, denial and reset sequences
module tb_tl_imem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  a_opcode = '0, a_param = '0;
    logic [3:0]  a_size = '0, a_mask = '0;
    logic [31:0] a_address = '0, a_data = '0;
    logic        a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_denied, d_corrupt, d_valid, d_ready = 1'b1;
    logic [31:0] d_data;

    int tests = 0, fails = 0;
    logic [2:0]  c_op;
    logic [3:0]  c_sz;
    logic        c_den, c_cor;
    logic [31:0] c_data;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[13];

    tl_imem_responder dut (
        .core_clock_i(clk), .core_reset_i(rst),
        .imem_a_opcode(a_opcode), .imem_a_param(a_param), .imem_a_size(a_size),
        .imem_a_address(a_address), .imem_a_mask(a_mask), .imem_a_data(a_data),
        .imem_a_corrupt(a_corrupt), .imem_a_valid(a_valid), .imem_a_ready(a_ready),
        .imem_d_opcode(d_opcode), .imem_d_param(d_param), .imem_d_size(d_size),
        .imem_d_denied(d_denied), .imem_d_data(d_data), .imem_d_corrupt(d_corrupt),
        .imem_d_valid(d_valid), .imem_d_ready(d_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input logic cor);
        int n = 0;
        a_opcode = op; a_size = sz; a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
        a_valid = 1'b1;
        while (!a_ready && n < 50) begin @(negedge clk); n++; end
        chk("a_accept", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic d_beat();
        int n = 0;
        while (!d_valid && n < 50) begin @(negedge clk); n++; end
        chk("d_arrive", 32'(d_valid), 32'd1);
        c_op = d_opcode; c_sz = d_size; c_den = d_denied; c_cor = d_corrupt; c_data = d_data;
        @(negedge clk);
    endtask

    task automatic put_word(input logic [31:0] addr, input logic [31:0] data);
        a_beat(3'd0, 4'd2, addr, 4'hF, data, 1'b0);
        d_beat();
    endtask

    task automatic get_word(input string nm, input logic [3:0] sz, input logic [31:0] addr, input logic [31:0] exp);
        a_beat(3'd4, sz, addr, 4'h0, 32'd0, 1'b0);
        d_beat();
        chk({nm, "_data"}, c_data, exp);
        chk({nm, "_den"}, 32'(c_den), 32'd0);
        chk({nm, "_size"}, 32'(c_sz), 32'(sz));
    endtask

    initial begin
        vecs[0]  = '{3'd0, 4'd2, 32'h300,  4'hF, 32'hCAFEF00D, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{3'd4, 4'd2, 32'h300,  4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'hCAFEF00D};
        vecs[2]  = '{3'd1, 4'd2, 32'h300,  4'h8, 32'h12345678, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[3]  = '{3'd4, 4'd2, 32'h300,  4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'h12FEF00D};
        vecs[4]  = '{3'd0, 4'd2, 32'h300,  4'hF, 32'h0,        1'b1, 3'd0, 1'b0, 32'h0};
        vecs[5]  = '{3'd4, 4'd2, 32'h300,  4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'h12FEF00D};
        vecs[6]  = '{3'd4, 4'd2, 32'h302,  4'h0, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0};
        vecs[7]  = '{3'd4, 4'd1, 32'h302,  4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'h12FEF00D};
        vecs[8]  = '{3'd4, 4'd2, 32'h4000, 4'h0, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0};
        vecs[9]  = '{3'd0, 4'd2, 32'h3FFC, 4'hF, 32'h55AA55AA, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[10] = '{3'd4, 4'd2, 32'h3FFC, 4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'h55AA55AA};
        vecs[11] = '{3'd0, 4'd2, 32'h4000, 4'hF, 32'h0BADBAD0, 1'b0, 3'd0, 1'b1, 32'h0};
        vecs[12] = '{3'd4, 4'd2, 32'h3FFC, 4'h0, 32'h0,        1'b0, 3'd1, 1'b0, 32'h55AA55AA};

        repeat (3) @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_opcode", 32'(d_opcode), 32'd0);
        chk("rst_d_param", 32'(d_param), 32'd0);
        chk("rst_d_size", 32'(d_size), 32'd0);
        chk("rst_d_denied", 32'(d_denied), 32'd0);
        chk("rst_d_corrupt", 32'(d_corrupt), 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            a_beat(vecs[i].op, vecs[i].sz, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].cor);
            d_beat();
            chk($sformatf("vec%0d_opcode", i), 32'(c_op), 32'(vecs[i].e_op));
            chk($sformatf("vec%0d_denied", i), 32'(c_den), 32'(vecs[i].e_den));
            chk($sformatf("vec%0d_corrupt", i), 32'(c_cor), 32'(vecs[i].e_den && vecs[i].e_op == 3'd1));
            chk($sformatf("vec%0d_size", i), 32'(c_sz), 32'(vecs[i].sz));
            if (vecs[i].e_op == 3'd1) chk($sformatf("vec%0d_data", i), c_data, vecs[i].e_data);
        end

        for (int i = 0; i < 32; i++) put_word(32'(4 * i), 32'h1000_0000 + 32'(i));

        a_beat(3'd4, 4'd6, 32'h40, 4'h0, 32'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("burst_valid%0d", k), 32'(d_valid), 32'd1);
            chk($sformatf("burst_data%0d", k), d_data, 32'h1000_0010 + 32'(k));
            chk($sformatf("burst_meta%0d", k), {25'd0, d_opcode, d_size}, {25'd0, 3'd1, 4'd6});
            chk($sformatf("burst_den%0d", k), 32'(d_denied), 32'd0);
            chk($sformatf("burst_param%0d", k), 32'(d_param), 32'd0);
            @(negedge clk);
        end
        chk("burst_end_valid", 32'(d_valid), 32'd0);
        chk("burst_end_a_ready", 32'(a_ready), 32'd1);

        a_beat(3'd4, 4'd6, 32'h40, 4'h0, 32'd0, 1'b0);
        begin
            int k = 0, cyc = 0;
            while (k < 16 && cyc < 100) begin
                chk($sformatf("stall_valid%0d", cyc), 32'(d_valid), 32'd1);
                chk($sformatf("stall_data%0d", cyc), d_data, 32'h1000_0010 + 32'(k));
                d_ready = cyc[0];
                if (d_ready) k++;
                @(negedge clk);
                cyc++;
            end
            d_ready = 1'b1;
            chk("stall_count", 32'(k), 32'd16);
            chk("stall_end_valid", 32'(d_valid), 32'd0);
        end

        put_word(32'h100, 32'h11223344);
        a_beat(3'd1, 4'd2, 32'h100, 4'b0101, 32'hAABBCCDD, 1'b0);
        d_beat();
        chk("pp_ack_op", 32'(c_op), 32'd0);
        chk("pp_ack_den", 32'(c_den), 32'd0);
        get_word("pp_read", 4'd2, 32'h100, 32'h11BB33DD);

        a_beat(3'd4, 4'd6, 32'h3FE0, 4'h0, 32'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            d_beat();
            chk($sformatf("dget_beat%0d", k), {c_op, c_den, c_cor, c_data}, {3'd1, 1'b1, 1'b1, 32'd0});
        end
        chk("dget_end_valid", 32'(d_valid), 32'd0);

        a_beat(3'd4, 4'd7, 32'h0, 4'h0, 32'd0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            d_beat();
            chk($sformatf("big_beat%0d", k), {c_op, c_den, c_cor, c_data}, {3'd1, 1'b1, 1'b1, 32'd0});
        end
        chk("big_end_valid", 32'(d_valid), 32'd0);

        a_beat(3'd3, 4'd2, 32'h40, 4'hF, 32'hDEADBEEF, 1'b0);
        d_beat();
        chk("op3_ack", {29'd0, c_op}, 32'd0);
        chk("op3_den", 32'(c_den), 32'd1);
        chk("op3_single", 32'(d_valid), 32'd0);
        get_word("op3_mem", 4'd2, 32'h40, 32'h1000_0010);

        a_beat(3'd0, 4'd3, 32'h400, 4'hF, 32'hA5A5_0001, 1'b0);
        a_beat(3'd0, 4'd3, 32'h400, 4'hF, 32'hA5A5_0002, 1'b0);
        chk("put2_ack_timing", 32'(d_valid), 32'd1);
        chk("put2_a_ready_ack", 32'(a_ready), 32'd0);
        d_beat();
        chk("put2_ack", {28'd0, c_op, c_den}, 32'd0);
        a_beat(3'd4, 4'd3, 32'h400, 4'h0, 32'd0, 1'b0);
        d_beat();
        chk("put2_rd0", c_data, 32'hA5A5_0001);
        d_beat();
        chk("put2_rd1", c_data, 32'hA5A5_0002);

        for (int i = 0; i < 4; i++) put_word(32'h200 + 32'(4 * i), 32'd0);
        a_beat(3'd0, 4'd4, 32'h200, 4'hF, 32'hB000_0000, 1'b0);
        a_beat(3'd0, 4'd4, 32'h200, 4'hF, 32'hB000_0001, 1'b0);
        rst = 1'b1;
        #1 chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        get_word("rst_w0", 4'd2, 32'h200, 32'hB000_0000);
        get_word("rst_w1", 4'd2, 32'h204, 32'hB000_0001);
        get_word("rst_w2", 4'd2, 32'h208, 32'd0);
        get_word("rst_w3", 4'd2, 32'h20C, 32'd0);

        get_word("sub_word", 4'd0, 32'h3, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
